// File: rtl/pellet_controller.sv
// Pac-Man pellet field: eaten mask, per-frame eat scan,
// score, pellets-left count and pellet pixel lookup.
module pellet_controller #(
  parameter int NUM_COLS   = 12,
  parameter int NUM_ROWS   = 10,
  parameter int X0         = 72,
  parameter int Y0         = 24,
  parameter int PITCH      = 48,
  parameter int EAT_RADIUS = 8,
  parameter int FOOD_HALF  = 0
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       Start,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       food_on,
  output logic [7:0] score,
  output logic [6:0] pellets_left,
  output logic       level_clear,
  output logic       busy
);

  localparam int NUM = NUM_COLS * NUM_ROWS;
  localparam int CW  = $clog2(NUM_COLS);
  localparam int RW  = $clog2(NUM_ROWS);

  localparam logic signed [10:0] RAD  = 11'(EAT_RADIUS);
  localparam logic signed [10:0] HALF = 11'(FOOD_HALF);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    PLAY,
    SCAN,
    CLEAR
  } state_t;

  state_t state, state_n;

  logic [NUM-1:0] mask;
  logic [6:0]     idx;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic           frame_prev;

  logic                frame_edge;
  logic [10:0]         cx, cy;
  logic signed [10:0]  dx, dy;
  logic                near;
  logic                eat;
  logic                last;
  logic [6:0]          left_after;

  assign frame_edge = frame_clk & ~frame_prev;

  // Scan centre tracks the col/row counters, not idx
  assign cx = 11'(X0) + 11'(PITCH) * 11'(col);
  assign cy = 11'(Y0) + 11'(PITCH) * 11'(row);

  assign dx = $signed({1'b0, BallX} - cx);
  assign dy = $signed({1'b0, BallY} - cy);

  assign near = (dx <= RAD) && (dx >= -RAD)
             && (dy <= RAD) && (dy >= -RAD);

  assign eat  = (state == SCAN) && mask[idx] && near;
  assign last = (idx == 7'(NUM - 1));

  assign left_after = eat ? pellets_left - 7'd1
                          : pellets_left;

  assign busy        = (state == SCAN);
  assign level_clear = (state == CLEAR);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (Start) state_n = FILL;
      FILL:  state_n = PLAY;
      PLAY:  if (frame_edge) state_n = SCAN;
      SCAN: begin
        if (last) begin
          state_n = (left_after == 7'd0) ? CLEAR : PLAY;
        end
      end
      CLEAR: if (Start) state_n = FILL;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mask         <= '0;
      score        <= '0;
      pellets_left <= '0;
      idx          <= '0;
      col          <= '0;
      row          <= '0;
      frame_prev   <= 1'b1;
    end else begin
      frame_prev <= frame_clk;
      unique case (state)
        IDLE: begin
          mask <= '0;
          if (Start) score <= '0;
        end
        FILL: begin
          mask         <= '1;
          pellets_left <= 7'(NUM);
          idx          <= '0;
          col          <= '0;
          row          <= '0;
        end
        PLAY: begin
          if (frame_edge) begin
            idx <= '0;
            col <= '0;
            row <= '0;
          end
        end
        SCAN: begin
          if (eat) begin
            mask[idx]    <= 1'b0;
            pellets_left <= left_after;
            if (score != 8'hff) score <= score + 8'd1;
          end
          idx <= idx + 7'd1;
          if (col == CW'(NUM_COLS - 1)) begin
            col <= '0;
            row <= row + RW'(1);
          end else begin
            col <= col + CW'(1);
          end
        end
        CLEAR: mask <= '0;
        default: mask <= '0;
      endcase
    end
  end

  // Column/row hit vectors; pitch keeps at most one hit per axis
  logic [NUM_COLS-1:0] col_hit;
  logic [NUM_ROWS-1:0] row_hit;

  always_comb begin
    logic signed [10:0] d;
    col_hit = '0;
    d       = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      d = $signed({1'b0, DrawX} - 11'(X0 + PITCH * c));
      col_hit[c] = (d <= HALF) && (d >= -HALF);
    end
  end

  always_comb begin
    logic signed [10:0] d;
    row_hit = '0;
    d       = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      d = $signed({1'b0, DrawY} - 11'(Y0 + PITCH * r));
      row_hit[r] = (d <= HALF) && (d >= -HALF);
    end
  end

  always_comb begin
    food_on = 1'b0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        food_on = food_on
                | (mask[r*NUM_COLS+c] & col_hit[c] & row_hit[r]);
      end
    end
  end

endmodule

// File: tb/tb_pellet_controller.sv
// Directed bench for pellet_controller with an
// expected-value queue popped as the DUT responds.
module tb_pellet_controller;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_clk;
  logic       Start;
  logic [9:0] BallX, BallY;
  logic [9:0] DrawX, DrawY;
  logic       food_on;
  logic [7:0] score;
  logic [6:0] pellets_left;
  logic       level_clear;
  logic       busy;

  pellet_controller dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_clk    (frame_clk),
    .Start        (Start),
    .BallX        (BallX),
    .BallY        (BallY),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .food_on      (food_on),
    .score        (score),
    .pellets_left (pellets_left),
    .level_clear  (level_clear),
    .busy         (busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    sbq.push_back('{tag, v});
  endtask

  task automatic pop(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $error("FAIL sb_underflow: got %0d want none", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s: got %0d want %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic food_at(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    #1;
    pop({31'd0, food_on});
  endtask

  task automatic run_scan(output int cycles);
    frame_clk = 1'b0;
    tick();
    frame_clk = 1'b1;
    tick();
    cycles = 0;
    while (busy && cycles < 300) begin
      cycles++;
      tick();
    end
  endtask

  task automatic ball(input int x, input int y);
    BallX = 10'(x);
    BallY = 10'(y);
  endtask

  int cyc;

  initial begin
    Reset_n   = 1'b0;
    frame_clk = 1'b1;
    Start     = 1'b0;
    BallX     = '0;
    BallY     = '0;
    DrawX     = 10'd72;
    DrawY     = 10'd24;
    repeat (3) tick();
    Reset_n = 1'b1;
    push("rst_busy", 0);
    push("rst_clear", 0);
    push("rst_score", 0);
    push("rst_left", 0);
    push("rst_food", 0);
    repeat (4) tick();
    pop({31'd0, busy});
    pop({31'd0, level_clear});
    pop({24'd0, score});
    pop({25'd0, pellets_left});
    food_at(72, 24);

    push("fill_left", 120);
    push("fill_score", 0);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    pop({25'd0, pellets_left});
    pop({24'd0, score});

    push("food_72_24", 1);
    push("food_73_24", 0);
    push("food_600_456", 1);
    push("food_648_24", 0);
    food_at(72, 24);
    food_at(73, 24);
    food_at(600, 456);
    food_at(648, 24);

    ball(72, 24);
    push("scan_len", 120);
    push("eat0_score", 1);
    push("eat0_left", 119);
    push("eat0_food", 0);
    run_scan(cyc);
    pop(32'(cyc));
    pop({24'd0, score});
    pop({25'd0, pellets_left});
    food_at(72, 24);

    push("reeat_score", 1);
    run_scan(cyc);
    pop({24'd0, score});

    ball(128, 24);
    push("dx8_score", 2);
    push("dx8_left", 118);
    run_scan(cyc);
    pop({24'd0, score});
    pop({25'd0, pellets_left});

    ball(129, 72);
    push("dx9_score", 2);
    run_scan(cyc);
    pop({24'd0, score});

    ball(96, 48);
    push("mid_score", 2);
    run_scan(cyc);
    pop({24'd0, score});

    ball(112, 80);
    push("neg_score", 3);
    push("neg_left", 117);
    push("neg_food", 0);
    run_scan(cyc);
    pop({24'd0, score});
    pop({25'd0, pellets_left});
    food_at(120, 72);

    push("walk_clear", 1);
    push("walk_left", 0);
    push("walk_score", 120);
    push("walk_busy", 0);
    push("walk_food", 0);
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 12; c++) begin
        ball(72 + 48 * c, 24 + 48 * r);
        run_scan(cyc);
      end
    end
    tick();
    pop({31'd0, level_clear});
    pop({25'd0, pellets_left});
    pop({24'd0, score});
    pop({31'd0, busy});
    food_at(600, 456);

    push("refill_left", 120);
    push("refill_score", 120);
    push("refill_clear", 0);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    pop({25'd0, pellets_left});
    pop({24'd0, score});
    pop({31'd0, level_clear});

    ball(0, 0);
    push("xedge_len", 120);
    push("xedge_idle", 0);
    frame_clk = 1'b0;
    tick();
    frame_clk = 1'b1;
    tick();
    cyc = 0;
    while (busy && cyc < 300) begin
      cyc++;
      if (cyc == 10) frame_clk = 1'b0;
      if (cyc == 11) frame_clk = 1'b1;
      tick();
    end
    pop(32'(cyc));
    repeat (5) tick();
    pop({31'd0, busy});

    ball(72, 24);
    push("mid_busy", 1);
    push("mr_score", 0);
    push("mr_left", 0);
    push("mr_busy", 0);
    push("mr_clear", 0);
    push("mr_food", 0);
    frame_clk = 1'b0;
    tick();
    frame_clk = 1'b1;
    tick();
    repeat (50) tick();
    pop({31'd0, busy});
    Reset_n = 1'b0;
    #1;
    pop({24'd0, score});
    pop({25'd0, pellets_left});
    pop({31'd0, busy});
    pop({31'd0, level_clear});
    food_at(72, 24);
    tick();
    Reset_n = 1'b1;
    tick();

    if (sbq.size() != 0) begin
      total++;
      bad++;
      $error("FAIL sb_leftover: got %0d want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
